// File: rtl/vec_pkg.sv
// Shared widths, state encoding and the bank-count clamp for the vector uop sequencer.
package vec_pkg;
    localparam int VLEN_W     = 12;
    localparam int MAX_BANKS  = 8;
    localparam int OP_W       = 8;
    localparam int BANK_CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Zero banks still makes forward progress one element per uop.
    function automatic logic [BANK_CNT_W-1:0] eff_banks_f(input logic [BANK_CNT_W-1:0] cnt);
        if (cnt == '0)
            return BANK_CNT_W'(1);
        else if (cnt > BANK_CNT_W'(MAX_BANKS))
            return BANK_CNT_W'(MAX_BANKS);
        else
            return cnt;
    endfunction
endpackage

// File: rtl/vec_lane_mask.sv
// Thermometer lane mask from an element count, saturating at MAX_BANKS lanes.
module vec_lane_mask
    import vec_pkg::*;
(
    input  logic [VLEN_W:0]    count,
    output logic [MAX_BANKS-1:0] mask
);
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_BANKS; i++)
            mask[i] = (count > (VLEN_W+1)'(i));
    end
endmodule

// File: rtl/vec_uop_sequencer.sv
// Strip-mines one vector command into element-group micro-ops, one group per cycle.
//   state | meaning
//   IDLE  | waiting for a command; cmd_rdy high
//   ISSUE | presenting groups until the last one fires
module vec_uop_sequencer
    import vec_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_val,
    output logic                  cmd_rdy,
    input  logic [OP_W-1:0]       cmd_op,
    input  logic [VLEN_W-1:0]     cmd_vlen,
    input  logic                  cmd_vlen_eq0,
    input  logic [BANK_CNT_W-1:0] vec_bank_count,
    output logic                  uop_val,
    input  logic                  uop_rdy,
    output logic [OP_W-1:0]       uop_op,
    output logic [VLEN_W-1:0]     uop_eidx,
    output logic [MAX_BANKS-1:0]  uop_mask,
    output logic                  uop_last,
    output logic                  busy,
    output logic                  done
);
    state_t                  state;
    logic [VLEN_W-1:0]       vlen_q;
    logic [BANK_CNT_W-1:0]   banks_q;
    logic [BANK_CNT_W-1:0]   acc_banks;
    logic [BANK_CNT_W-1:0]   grp_banks;
    logic [VLEN_W:0]         eidx_next;
    logic [VLEN_W:0]         rem_next;
    logic [VLEN_W:0]         grp_cnt;
    logic [MAX_BANKS-1:0]    mask_next;
    logic                    last_next;
    logic                    acc_zero;
    logic                    accept;
    logic                    fire;

    assign cmd_rdy   = (state == IDLE);
    assign busy      = (state == ISSUE);
    assign accept    = cmd_val & cmd_rdy;
    assign fire      = uop_val & uop_rdy;
    assign acc_banks = eff_banks_f(vec_bank_count);
    assign acc_zero  = cmd_vlen_eq0 | (cmd_vlen == '0);

    // One mask generator serves both the first group (from the incoming command)
    // and every following group (from the latched command).
    always_comb begin
        eidx_next = {1'b0, uop_eidx} + (VLEN_W+1)'(banks_q);
        rem_next  = '0;
        grp_banks = banks_q;
        if (state == IDLE) begin
            rem_next  = {1'b0, cmd_vlen};
            grp_banks = acc_banks;
        end else begin
            rem_next  = {1'b0, vlen_q} - eidx_next;
        end
        grp_cnt   = (rem_next < (VLEN_W+1)'(grp_banks)) ? rem_next : (VLEN_W+1)'(grp_banks);
        last_next = (rem_next <= (VLEN_W+1)'(grp_banks));
    end

    vec_lane_mask u_lane_mask (
        .count (grp_cnt),
        .mask  (mask_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            vlen_q   <= '0;
            banks_q  <= BANK_CNT_W'(1);
            uop_val  <= 1'b0;
            uop_op   <= '0;
            uop_eidx <= '0;
            uop_mask <= '0;
            uop_last <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        uop_op  <= cmd_op;
                        vlen_q  <= cmd_vlen;
                        banks_q <= acc_banks;
                        if (acc_zero) begin
                            done <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            uop_val  <= 1'b1;
                            uop_eidx <= '0;
                            uop_mask <= mask_next;
                            uop_last <= last_next;
                        end
                    end
                end
                ISSUE: begin
                    if (fire) begin
                        if (uop_last) begin
                            state    <= IDLE;
                            uop_val  <= 1'b0;
                            uop_mask <= '0;
                            uop_last <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            uop_eidx <= eidx_next[VLEN_W-1:0];
                            uop_mask <= mask_next;
                            uop_last <= last_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_uop_sequencer.sv
// Directed bench for vec_uop_sequencer; expected values are hand-computed per scenario.
module tb_vec_uop_sequencer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_val;
    logic        cmd_rdy;
    logic [7:0]  cmd_op;
    logic [11:0] cmd_vlen;
    logic        cmd_vlen_eq0;
    logic [3:0]  vec_bank_count;
    logic        uop_val;
    logic        uop_rdy;
    logic [7:0]  uop_op;
    logic [11:0] uop_eidx;
    logic [7:0]  uop_mask;
    logic        uop_last;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vec_uop_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_val        (cmd_val),
        .cmd_rdy        (cmd_rdy),
        .cmd_op         (cmd_op),
        .cmd_vlen       (cmd_vlen),
        .cmd_vlen_eq0   (cmd_vlen_eq0),
        .vec_bank_count (vec_bank_count),
        .uop_val        (uop_val),
        .uop_rdy        (uop_rdy),
        .uop_op         (uop_op),
        .uop_eidx       (uop_eidx),
        .uop_mask       (uop_mask),
        .uop_last       (uop_last),
        .busy           (busy),
        .done           (done)
    );

    // Called on a falling edge with cmd_rdy high; returns one falling edge after accept.
    task automatic issue(input logic [7:0] op, input logic [11:0] vl, input logic eq0,
                         input logic [3:0] bk);
        cmd_val        = 1'b1;
        cmd_op         = op;
        cmd_vlen       = vl;
        cmd_vlen_eq0   = eq0;
        vec_bank_count = bk;
        @(negedge clk);
        cmd_val      = 1'b0;
        cmd_vlen_eq0 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cmd_val = 1'b0; cmd_op = '0; cmd_vlen = '0; cmd_vlen_eq0 = 1'b0;
        vec_bank_count = '0; uop_rdy = 1'b0;
        #12;
        checks++;
        if ({uop_val, uop_last, busy, done, cmd_rdy} !== 5'b00001 || uop_eidx !== 12'd0
            || uop_mask !== 8'h00) begin
            errors++;
            $display("FAIL reset: val=%b last=%b busy=%b done=%b rdy=%b eidx=%0d mask=%h exp 0/0/0/0/1/0/00",
                     uop_val, uop_last, busy, done, cmd_rdy, uop_eidx, uop_mask);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [11:0] exp_e [3] = '{12'd0, 12'd4, 12'd8};
        logic [7:0]  exp_m [3] = '{8'h0F, 8'h0F, 8'h03};
        logic        exp_l [3] = '{1'b0, 1'b0, 1'b1};
        uop_rdy = 1'b1;
        issue(8'hA5, 12'd10, 1'b0, 4'd4);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (uop_val !== 1'b1 || uop_eidx !== exp_e[i] || uop_mask !== exp_m[i]
                || uop_last !== exp_l[i] || uop_op !== 8'hA5 || busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_uop%0d: val=%b eidx=%0d mask=%h last=%b op=%h busy=%b exp 1/%0d/%h/%b/a5/1",
                         i, uop_val, uop_eidx, uop_mask, uop_last, uop_op, busy,
                         exp_e[i], exp_m[i], exp_l[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || uop_val !== 1'b0 || cmd_rdy !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b val=%b rdy=%b busy=%b exp 1/0/1/0",
                     done, uop_val, cmd_rdy, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b exp 0", done);
        end
    endtask

    task automatic test_zero_len();
        logic [11:0] vls [3]  = '{12'd0, 12'd7, 12'd0};
        logic        eqs [3]  = '{1'b1, 1'b1, 1'b0};
        uop_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(8'h11, vls[i], eqs[i], 4'd4);
            checks++;
            if (done !== 1'b1 || uop_val !== 1'b0 || cmd_rdy !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_len%0d: done=%b val=%b rdy=%b busy=%b exp 1/0/1/0",
                         i, done, uop_val, cmd_rdy, busy);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || uop_val !== 1'b0) begin
                errors++;
                $display("FAIL zero_len_after%0d: done=%b val=%b exp 0/0", i, done, uop_val);
            end
        end
    endtask

    task automatic test_stall();
        uop_rdy = 1'b0;
        issue(8'h3C, 12'd8, 1'b0, 4'd4);
        vec_bank_count = 4'd1;
        cmd_val = 1'b1; cmd_op = 8'hEE; cmd_vlen = 12'd1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (uop_val !== 1'b1 || uop_eidx !== 12'd0 || uop_mask !== 8'h0F
                || uop_last !== 1'b0 || uop_op !== 8'h3C || cmd_rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: val=%b eidx=%0d mask=%h last=%b op=%h rdy=%b exp 1/0/0f/0/3c/0",
                         i, uop_val, uop_eidx, uop_mask, uop_last, uop_op, cmd_rdy);
            end
            if (i < 2) @(negedge clk);
        end
        uop_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (uop_val !== 1'b1 || uop_eidx !== 12'd4 || uop_mask !== 8'h0F || uop_last !== 1'b1
            || uop_op !== 8'h3C) begin
            errors++;
            $display("FAIL stall_uop2: val=%b eidx=%0d mask=%h last=%b op=%h exp 1/4/0f/1/3c",
                     uop_val, uop_eidx, uop_mask, uop_last, uop_op);
        end
        cmd_val = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || uop_val !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done=%b val=%b exp 1/0", done, uop_val);
        end
        @(negedge clk);
    endtask

    task automatic test_bank_clamp();
        logic [11:0] exp_e [3] = '{12'd0, 12'd8, 12'd16};
        logic [7:0]  exp_m [3] = '{8'hFF, 8'hFF, 8'h0F};
        uop_rdy = 1'b1;
        issue(8'h01, 12'd2, 1'b0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (uop_val !== 1'b1 || uop_eidx !== 12'(i) || uop_mask !== 8'h01
                || uop_last !== (i == 1)) begin
                errors++;
                $display("FAIL banks0_uop%0d: val=%b eidx=%0d mask=%h last=%b exp 1/%0d/01/%b",
                         i, uop_val, uop_eidx, uop_mask, uop_last, i, (i == 1));
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL banks0_done: done=%b exp 1", done);
        end
        @(negedge clk);
        issue(8'h02, 12'd20, 1'b0, 4'd15);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (uop_val !== 1'b1 || uop_eidx !== exp_e[i] || uop_mask !== exp_m[i]
                || uop_last !== (i == 2)) begin
                errors++;
                $display("FAIL banks15_uop%0d: val=%b eidx=%0d mask=%h last=%b exp 1/%0d/%h/%b",
                         i, uop_val, uop_eidx, uop_mask, uop_last, exp_e[i], exp_m[i], (i == 2));
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL banks15_done: done=%b exp 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        uop_rdy = 1'b1;
        issue(8'h77, 12'd12, 1'b0, 4'd4);
        @(negedge clk);
        checks++;
        if (uop_val !== 1'b1 || uop_eidx !== 12'd4) begin
            errors++;
            $display("FAIL midrst_uop2: val=%b eidx=%0d exp 1/4", uop_val, uop_eidx);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (uop_val !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || uop_eidx !== 12'd0) begin
            errors++;
            $display("FAIL midrst_immediate: val=%b busy=%b done=%b eidx=%0d exp 0/0/0/0",
                     uop_val, busy, done, uop_eidx);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || uop_val !== 1'b0 || cmd_rdy !== 1'b1) begin
                errors++;
                $display("FAIL midrst_nodone%0d: done=%b val=%b rdy=%b exp 0/0/1",
                         i, done, uop_val, cmd_rdy);
            end
        end
        issue(8'h78, 12'd5, 1'b0, 4'd4);
        checks++;
        if (uop_val !== 1'b1 || uop_eidx !== 12'd0 || uop_mask !== 8'h0F || uop_last !== 1'b0
            || uop_op !== 8'h78) begin
            errors++;
            $display("FAIL midrst_next0: val=%b eidx=%0d mask=%h last=%b op=%h exp 1/0/0f/0/78",
                     uop_val, uop_eidx, uop_mask, uop_last, uop_op);
        end
        @(negedge clk);
        checks++;
        if (uop_val !== 1'b1 || uop_eidx !== 12'd4 || uop_mask !== 8'h01 || uop_last !== 1'b1) begin
            errors++;
            $display("FAIL midrst_next1: val=%b eidx=%0d mask=%h last=%b exp 1/4/01/1",
                     uop_val, uop_eidx, uop_mask, uop_last);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_max_len();
        int n_uops   = 0;
        int n_done   = 0;
        int bad_eidx = 0;
        logic [11:0] last_e = '0;
        logic [7:0]  last_m = '0;
        uop_rdy = 1'b1;
        issue(8'h5A, 12'd4095, 1'b0, 4'd8);
        for (int c = 0; c < 600; c++) begin
            if (uop_val) begin
                if (uop_eidx !== 12'(n_uops * 8)) bad_eidx++;
                n_uops++;
                if (uop_last) begin
                    last_e = uop_eidx;
                    last_m = uop_mask;
                end
            end
            if (done) n_done++;
            @(negedge clk);
        end
        checks++;
        if (n_uops != 512 || n_done != 1) begin
            errors++;
            $display("FAIL maxlen_counts: uops=%0d done_pulses=%0d exp 512/1", n_uops, n_done);
        end
        checks++;
        if (last_e !== 12'd4088 || last_m !== 8'h7F || bad_eidx != 0) begin
            errors++;
            $display("FAIL maxlen_last: eidx=%0d mask=%h bad_steps=%0d exp 4088/7f/0",
                     last_e, last_m, bad_eidx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_bank_clamp();
        test_mid_reset();
        test_max_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
